cos_harmonic_accum: RTL

- Streaming cosine-weighted accumulator bank for the pitch/T-function path.
- Accepts one signed spectrum sample per valid cycle, index i = 0..I_MAX-1 within a frame.
- For each harmonic channel k (0..NU_VALUES-1), emits the running sum S_k(i) = sum over j≤i of (x_j·cos(2π·k·j/I_MAX)) >>> (COS_FRAC+SCALE_SHIFT), one result per sample, addressed for BRAM write-back.
- Generalises the fixed 3-channel version: parametrised channel count, gapped input, explicit frame end, saturation and error reporting.

---
 rtl/cos_harmonic_accum.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cos_harmonic_accum.sv
`default_nettype none
// ============================================================================
// Module   : cos_harmonic_accum
// Brief    : Streaming cosine-weighted accumulator bank; one saturating running
//            sum per harmonic channel per accepted sample, BRAM-addressed.
// Revision : 1.0 - initial release
// ============================================================================
module cos_harmonic_accum #(
    parameter int DATA_W      = 32,
    parameter int COS_W       = 16,
    parameter int NU_VALUES   = 3,
    parameter int I_MAX       = 160,
    parameter int SCALE_SHIFT = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          in_valid,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    output logic [$clog2(I_MAX)-1:0]      out_addr,
    output logic [NU_VALUES*DATA_W-1:0]   out_sums,
    output logic                          out_last,
    output logic                          out_sat,
    output logic                          out_frame_err
);

    localparam int  c_aw    = $clog2(I_MAX);
    localparam int  c_shift = COS_W - 2 + SCALE_SHIFT;
    localparam int  c_pw    = DATA_W + COS_W;
    localparam int  c_one   = 1 << (COS_W - 2);
    localparam real c_pi    = 3.14159265358979323846;
    localparam logic signed [DATA_W:0] c_max = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0] c_min = {2'b11, {(DATA_W-1){1'b0}}};

    // Elaboration-time cosine sample in Q1.(COS_W-2), rounded half away from zero.
    function automatic logic signed [COS_W-1:0] cos_q(input int a);
        real v;
        int  r;
        v = (2.0 ** (COS_W - 2)) * $cos(2.0 * c_pi * a / I_MAX);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(0.5 - v);
        if (r > c_one) r = c_one;
        return COS_W'(r);
    endfunction

    logic signed [COS_W-1:0] w_rom [I_MAX];

    for (genvar a = 0; a < I_MAX; a++) begin : g_rom
        assign w_rom[a] = cos_q(a);
    end

    // Frame tracking at the input
    logic [c_aw-1:0] r_idx;
    logic            w_end;

    assign w_end = in_last | (r_idx == c_aw'(I_MAX - 1));

    // Pipeline sideband: A = accepted, B = cosine read, C = product
    logic                     r_a_valid, r_b_valid, r_c_valid;
    logic signed [DATA_W-1:0] r_a_data, r_b_data;
    logic [c_aw-1:0]          r_a_idx, r_b_idx, r_c_idx;
    logic                     r_a_last, r_b_last, r_c_last;
    logic                     r_a_err, r_b_err, r_c_err;
    logic                     r_sat;
    logic                     w_c_first;
    logic                     w_frame_sat;
    logic [NU_VALUES-1:0]     w_clamp;

    assign w_c_first   = (r_c_idx == '0);
    assign w_frame_sat = (|w_clamp) | (r_sat & ~w_c_first);

    for (genvar k = 0; k < NU_VALUES; k++) begin : g_ch
        logic [c_aw-1:0]          r_phase;
        logic [c_aw-1:0]          r_addr;
        logic [c_aw:0]            w_psum;
        logic [c_aw-1:0]          w_pnext;
        logic signed [COS_W-1:0]  r_cos;
        logic signed [c_pw-1:0]   w_prod;
        logic signed [DATA_W-1:0] r_prod;
        logic signed [DATA_W:0]   w_sum;
        logic signed [DATA_W:0]   w_base;
        logic signed [DATA_W-1:0] r_acc;
        logic                     w_hi, w_lo;

        // Incremental phase step; k < I_MAX so one conditional subtract wraps it.
        assign w_psum  = {1'b0, r_phase} + (c_aw+1)'(k);
        assign w_pnext = (w_psum >= (c_aw+1)'(I_MAX)) ?
                         c_aw'(w_psum - (c_aw+1)'(I_MAX)) : w_psum[c_aw-1:0];

        assign w_prod = r_b_data * r_cos;
        assign w_base = w_c_first ? '0 : {r_acc[DATA_W-1], r_acc};
        assign w_sum  = w_base + {r_prod[DATA_W-1], r_prod};
        assign w_hi   = (w_sum > c_max);
        assign w_lo   = (w_sum < c_min);

        assign w_clamp[k] = r_c_valid & (w_hi | w_lo);
        assign out_sums[k*DATA_W +: DATA_W] = r_acc;

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_phase <= '0;
                r_addr  <= '0;
                r_cos   <= '0;
                r_prod  <= '0;
                r_acc   <= '0;
            end else begin
                if (in_valid) begin
                    r_addr  <= r_phase;
                    r_phase <= w_end ? '0 : w_pnext;
                end
                r_cos  <= w_rom[r_addr];
                r_prod <= DATA_W'(w_prod >>> c_shift);
                if (r_c_valid) begin
                    if (w_hi)      r_acc <= c_max[DATA_W-1:0];
                    else if (w_lo) r_acc <= c_min[DATA_W-1:0];
                    else           r_acc <= w_sum[DATA_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_idx         <= '0;
            r_a_valid     <= 1'b0;
            r_a_data      <= '0;
            r_a_idx       <= '0;
            r_a_last      <= 1'b0;
            r_a_err       <= 1'b0;
            r_b_valid     <= 1'b0;
            r_b_data      <= '0;
            r_b_idx       <= '0;
            r_b_last      <= 1'b0;
            r_b_err       <= 1'b0;
            r_c_valid     <= 1'b0;
            r_c_idx       <= '0;
            r_c_last      <= 1'b0;
            r_c_err       <= 1'b0;
            r_sat         <= 1'b0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_last      <= 1'b0;
            out_sat       <= 1'b0;
            out_frame_err <= 1'b0;
        end else begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_data <= in_data;
                r_a_idx  <= r_idx;
                r_a_last <= w_end;
                r_a_err  <= w_end & ~in_last;
                r_idx    <= w_end ? '0 : r_idx + c_aw'(1);
            end

            r_b_valid <= r_a_valid;
            r_b_data  <= r_a_data;
            r_b_idx   <= r_a_idx;
            r_b_last  <= r_a_last;
            r_b_err   <= r_a_err;

            r_c_valid <= r_b_valid;
            r_c_idx   <= r_b_idx;
            r_c_last  <= r_b_last;
            r_c_err   <= r_b_err;

            out_valid <= r_c_valid;
            if (r_c_valid) begin
                out_addr      <= r_c_idx;
                out_last      <= r_c_last;
                out_sat       <= r_c_last & w_frame_sat;
                out_frame_err <= r_c_last & r_c_err;
                r_sat         <= r_c_last ? 1'b0 : w_frame_sat;
            end
        end
    end

endmodule
`default_nettype wire
